yacht_game_ctrl_n: RTL and testbench

- Parametrised N-player Yacht turn/score controller.
- Sequences players, rounds, rolls (up to MAX_ROLLS per turn) and category selection.
- Tracks per-player used categories, totals and upper-section sums; applies the upper bonus; determines the winner.
- Sits between the debounced button front-end and dice/score-calc/display blocks.

---
 rtl/yacht_pkg.sv | 38 +++
 rtl/yacht_cat_cursor.sv | 32 +++
 rtl/yacht_game_ctrl_n.sv | 217 +++++++++++++++++++++
 tb/tb_yacht_game_ctrl_n.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yacht_pkg.sv
// Shared types and helpers for the Yacht turn/score controller.
package yacht_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_TURN   = 4'd1,
      S_WAIT   = 4'd2,
      S_ROLL   = 4'd3,
      S_SELECT = 4'd4,
      S_COMMIT = 4'd5,
      S_NEXT   = 4'd6,
      S_BONUS  = 4'd7,
      S_RESULT = 4'd8,
      S_END    = 4'd9
   } state_t;

   localparam int CAT_ONES        = 0;
   localparam int CAT_TWOS        = 1;
   localparam int CAT_THREES      = 2;
   localparam int CAT_FOURS       = 3;
   localparam int CAT_FIVES       = 4;
   localparam int CAT_SIXES       = 5;
   localparam int CAT_CHOICE      = 6;
   localparam int CAT_FOUR_KIND   = 7;
   localparam int CAT_FULL_HOUSE  = 8;
   localparam int CAT_SM_STRAIGHT = 9;
   localparam int CAT_LG_STRAIGHT = 10;
   localparam int CAT_YACHT       = 11;

   function automatic int unsigned sat_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned maxv);
      int unsigned s;
      s = a + b;
      return (s > maxv) ? maxv : s;
   endfunction

endpackage

// File: rtl/yacht_cat_cursor.sv
// Finds the lowest unused category, or the next/previous unused one with wrap.
module yacht_cat_cursor #(
   parameter int NUM_CATS = 12
) (
   input  logic [NUM_CATS-1:0]         used_mask,
   input  logic [$clog2(NUM_CATS)-1:0] idx,
   input  logic                        dir,
   input  logic                        first,
   output logic [$clog2(NUM_CATS)-1:0] next_idx
);
   localparam int CW = $clog2(NUM_CATS);

   // Descending loops so the smallest matching distance is the final write.
   always_comb begin
      int j;
      j        = 0;
      next_idx = idx;
      if (first) begin
         next_idx = '0;
         for (int i = NUM_CATS - 1; i >= 0; i--) begin
            if (!used_mask[i]) next_idx = CW'(i);
         end
      end else begin
         for (int k = NUM_CATS - 1; k >= 1; k--) begin
            if (dir) j = (int'(idx) + k) % NUM_CATS;
            else     j = (int'(idx) + NUM_CATS - k) % NUM_CATS;
            if (!used_mask[j]) next_idx = CW'(j);
         end
      end
   end

endmodule

// File: rtl/yacht_game_ctrl_n.sv
// N-player Yacht controller: turn/roll sequencing, category choice, scoring,
// end-of-game upper bonus and winner scan.
//
//   state    | meaning
//   S_IDLE   | waiting for first roll of a new game
//   S_TURN   | start of a player's turn, clears roll count
//   S_WAIT   | waiting for roll or select
//   S_ROLL   | one-cycle dice roll strobe
//   S_SELECT | browsing unused categories
//   S_COMMIT | add score to the active player
//   S_NEXT   | advance player / round
//   S_BONUS  | apply upper-section bonus
//   S_RESULT | one-player-per-cycle winner scan
//   S_END    | game over, waiting for roll to restart
module yacht_game_ctrl_n
   import yacht_pkg::*;
#(
   parameter int NUM_PLAYERS  = 2,
   parameter int NUM_CATS     = 12,
   parameter int MAX_ROLLS    = 3,
   parameter int UPPER_CATS   = 6,
   parameter int BONUS_THRESH = 63,
   parameter int BONUS_PTS    = 35,
   parameter int SCORE_W      = 10
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             btn_roll,
   input  logic                             btn_sel,
   input  logic                             btn_prev,
   input  logic                             btn_next,
   input  logic [7:0]                       calc_score,
   input  logic [$clog2(NUM_PLAYERS)-1:0]   score_rd_sel,
   output logic [3:0]                       state_dbg,
   output logic [$clog2(NUM_PLAYERS)-1:0]   player,
   output logic                             roll_trigger,
   output logic [2:0]                       roll_cnt,
   output logic [$clog2(NUM_CATS)-1:0]      category_idx,
   output logic [$clog2(NUM_CATS+1)-1:0]    round_num,
   output logic [NUM_CATS-1:0]              used_mask,
   output logic [SCORE_W-1:0]               score_rd,
   output logic                             game_over,
   output logic [$clog2(NUM_PLAYERS)-1:0]   winner,
   output logic                             tie
);
   localparam int PW = $clog2(NUM_PLAYERS);
   localparam int CW = $clog2(NUM_CATS);
   localparam int RW = $clog2(NUM_CATS + 1);
   localparam int unsigned SMAX = (2 ** SCORE_W) - 1;

   state_t              state_q;
   logic [PW-1:0]       player_q;
   logic [2:0]          roll_cnt_q;
   logic [CW-1:0]       cat_q;
   logic [RW-1:0]       round_q;
   logic [SCORE_W-1:0]  score_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]  upper_q [NUM_PLAYERS];
   logic [NUM_CATS-1:0] used_q  [NUM_PLAYERS];
   logic                game_over_q;
   logic [PW-1:0]       winner_q;
   logic                tie_q;
   logic [PW-1:0]       scan_q;
   logic [SCORE_W-1:0]  best_q;
   logic [CW-1:0]       cursor_idx;

   yacht_cat_cursor #(.NUM_CATS(NUM_CATS)) u_cursor (
      .used_mask (used_q[player_q]),
      .idx       (cat_q),
      .dir       (btn_next),
      .first     (state_q != S_SELECT),
      .next_idx  (cursor_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         player_q    <= '0;
         roll_cnt_q  <= '0;
         cat_q       <= '0;
         round_q     <= RW'(1);
         game_over_q <= 1'b0;
         winner_q    <= '0;
         tie_q       <= 1'b0;
         scan_q      <= '0;
         best_q      <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            score_q[p] <= '0;
            upper_q[p] <= '0;
            used_q[p]  <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (btn_roll) begin
                  player_q   <= '0;
                  round_q    <= RW'(1);
                  roll_cnt_q <= '0;
                  state_q    <= S_ROLL;
               end
            end
            S_TURN: begin
               roll_cnt_q <= '0;
               state_q    <= S_WAIT;
            end
            S_WAIT: begin
               if (btn_roll && (roll_cnt_q < 3'(MAX_ROLLS))) begin
                  state_q <= S_ROLL;
               end else if (btn_sel && (roll_cnt_q != 3'd0)) begin
                  cat_q   <= cursor_idx;
                  state_q <= S_SELECT;
               end
            end
            S_ROLL: begin
               roll_cnt_q <= roll_cnt_q + 3'd1;
               if ((roll_cnt_q + 3'd1) == 3'(MAX_ROLLS)) begin
                  cat_q   <= cursor_idx;
                  state_q <= S_SELECT;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_SELECT: begin
               if (btn_sel) begin
                  state_q <= S_COMMIT;
               end else if (btn_next || btn_prev) begin
                  cat_q <= cursor_idx;
               end
            end
            S_COMMIT: begin
               score_q[player_q] <= SCORE_W'(sat_add(32'(score_q[player_q]),
                                                     32'(calc_score), SMAX));
               if (int'(cat_q) < UPPER_CATS) begin
                  upper_q[player_q] <= SCORE_W'(sat_add(32'(upper_q[player_q]),
                                                        32'(calc_score), SMAX));
               end
               used_q[player_q][cat_q] <= 1'b1;
               state_q <= S_NEXT;
            end
            S_NEXT: begin
               if (player_q != PW'(NUM_PLAYERS - 1)) begin
                  player_q <= player_q + PW'(1);
                  state_q  <= S_TURN;
               end else if (round_q < RW'(NUM_CATS)) begin
                  player_q <= '0;
                  round_q  <= round_q + RW'(1);
                  state_q  <= S_TURN;
               end else begin
                  state_q <= S_BONUS;
               end
            end
            S_BONUS: begin
               for (int p = 0; p < NUM_PLAYERS; p++) begin
                  if (upper_q[p] >= SCORE_W'(BONUS_THRESH)) begin
                     score_q[p] <= SCORE_W'(sat_add(32'(score_q[p]),
                                                    32'(BONUS_PTS), SMAX));
                  end
               end
               scan_q  <= '0;
               state_q <= S_RESULT;
            end
            S_RESULT: begin
               // Strict > keeps the lowest index as winner on equal totals.
               if (scan_q == '0) begin
                  winner_q <= '0;
                  tie_q    <= 1'b0;
                  best_q   <= score_q[0];
               end else if (score_q[scan_q] > best_q) begin
                  winner_q <= scan_q;
                  tie_q    <= 1'b0;
                  best_q   <= score_q[scan_q];
               end else if (score_q[scan_q] == best_q) begin
                  tie_q <= 1'b1;
               end
               if (scan_q == PW'(NUM_PLAYERS - 1)) begin
                  game_over_q <= 1'b1;
                  state_q     <= S_END;
               end else begin
                  scan_q <= scan_q + PW'(1);
               end
            end
            S_END: begin
               if (btn_roll) begin
                  player_q    <= '0;
                  roll_cnt_q  <= '0;
                  cat_q       <= '0;
                  round_q     <= RW'(1);
                  game_over_q <= 1'b0;
                  winner_q    <= '0;
                  tie_q       <= 1'b0;
                  scan_q      <= '0;
                  best_q      <= '0;
                  for (int p = 0; p < NUM_PLAYERS; p++) begin
                     score_q[p] <= '0;
                     upper_q[p] <= '0;
                     used_q[p]  <= '0;
                  end
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign state_dbg    = state_q;
   assign player       = player_q;
   assign roll_trigger = (state_q == S_ROLL);
   assign roll_cnt     = roll_cnt_q;
   assign category_idx = cat_q;
   assign round_num    = round_q;
   assign used_mask    = used_q[player_q];
   assign score_rd     = score_q[score_rd_sel];
   assign game_over    = game_over_q;
   assign winner       = winner_q;
   assign tie          = tie_q;

endmodule

// File: tb/tb_yacht_game_ctrl_n.sv
// Directed bench for yacht_game_ctrl_n with default parameters (2 players, 12 cats, 3 rolls).
module tb_yacht_game_ctrl_n;

   localparam int ST_IDLE = 0, ST_WAIT = 2, ST_ROLL = 3, ST_SELECT = 4,
                  ST_COMMIT = 5, ST_NEXT = 6, ST_END = 9;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        btn_roll, btn_sel, btn_prev, btn_next;
   logic [7:0]  calc_score;
   logic [0:0]  score_rd_sel;
   logic [3:0]  state_dbg;
   logic [0:0]  player;
   logic        roll_trigger;
   logic [2:0]  roll_cnt;
   logic [3:0]  category_idx;
   logic [3:0]  round_num;
   logic [11:0] used_mask;
   logic [9:0]  score_rd;
   logic        game_over;
   logic [0:0]  winner;
   logic        tie;

   int tests  = 0;
   int failed = 0;

   int p0s [12] = '{15, 18, 12, 8, 10, 0, 10, 10, 10, 10, 10, 2};
   int p1s [12] = '{18, 12, 15, 8, 9, 0, 20, 20, 20, 20, 8, 0};

   yacht_game_ctrl_n dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .btn_roll     (btn_roll),
      .btn_sel      (btn_sel),
      .btn_prev     (btn_prev),
      .btn_next     (btn_next),
      .calc_score   (calc_score),
      .score_rd_sel (score_rd_sel),
      .state_dbg    (state_dbg),
      .player       (player),
      .roll_trigger (roll_trigger),
      .roll_cnt     (roll_cnt),
      .category_idx (category_idx),
      .round_num    (round_num),
      .used_mask    (used_mask),
      .score_rd     (score_rd),
      .game_over    (game_over),
      .winner       (winner),
      .tie          (tie)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_roll(); btn_roll = 1'b1; tick(); btn_roll = 1'b0; endtask
   task automatic pulse_sel();  btn_sel  = 1'b1; tick(); btn_sel  = 1'b0; endtask
   task automatic pulse_next(); btn_next = 1'b1; tick(); btn_next = 1'b0; endtask
   task automatic pulse_prev(); btn_prev = 1'b1; tick(); btn_prev = 1'b0; endtask

   task automatic chk_score(input string tag, input int p, input int exp);
      score_rd_sel = 1'(p);
      #1;
      chk(tag, 32'(score_rd), exp);
   endtask

   task automatic wait_turn_or_end();
      int n;
      n = 0;
      while (state_dbg != 4'(ST_WAIT) && state_dbg != 4'(ST_END) && n < 40) begin
         tick();
         n++;
      end
      chk("wait_timeout", 32'(n < 40), 1);
   endtask

   // Rolls nrolls times, selects the lowest unused category and commits sc.
   task automatic do_turn(input int nrolls, input int sc);
      for (int i = 0; i < nrolls; i++) begin
         pulse_roll();
         tick();
      end
      if (nrolls < 3) pulse_sel();
      calc_score = 8'(sc);
      pulse_sel();
      tick();
      calc_score = '0;
      wait_turn_or_end();
   endtask

   initial begin
      reset_n = 1'b0;
      btn_roll = 0; btn_sel = 0; btn_prev = 0; btn_next = 0;
      calc_score = '0;
      score_rd_sel = '0;
      repeat (3) tick();
      chk("rst_state", 32'(state_dbg), ST_IDLE);
      chk("rst_player", 32'(player), 0);
      chk("rst_roll_cnt", 32'(roll_cnt), 0);
      chk("rst_cat", 32'(category_idx), 0);
      chk("rst_round", 32'(round_num), 1);
      chk("rst_used", 32'(used_mask), 0);
      chk("rst_trigger", 32'(roll_trigger), 0);
      chk("rst_game_over", 32'(game_over), 0);
      chk("rst_winner_tie", {30'd0, winner, tie}, 0);
      chk("rst_score", 32'(score_rd), 0);
      reset_n = 1'b1;
      tick();

      // ---- Game 1, round 1, player 0: roll once, navigate to category 2
      pulse_roll();
      chk("r1_roll_state", 32'(state_dbg), ST_ROLL);
      chk("r1_trigger", 32'(roll_trigger), 1);
      tick();
      chk("r1_wait_state", 32'(state_dbg), ST_WAIT);
      chk("r1_roll_cnt", 32'(roll_cnt), 1);
      chk("r1_trigger_low", 32'(roll_trigger), 0);
      pulse_sel();
      chk("r1_select", 32'(state_dbg), ST_SELECT);
      chk("r1_entry_idx", 32'(category_idx), 0);
      pulse_next();
      chk("r1_next1", 32'(category_idx), 1);
      pulse_next();
      chk("r1_next2", 32'(category_idx), 2);
      calc_score = 8'(p0s[0]);
      btn_next = 1'b1;
      pulse_sel();
      btn_next = 1'b0;
      chk("r1_commit_state", 32'(state_dbg), ST_COMMIT);
      tick();
      calc_score = '0;
      chk("r1_next_state", 32'(state_dbg), ST_NEXT);
      chk("r1_used_p0", 32'(used_mask), 12'b0000_0000_0100);
      chk_score("r1_score_p0", 0, 15);
      wait_turn_or_end();
      chk("r1_player1", 32'(player), 1);
      chk("r1_p1_roll_cnt", 32'(roll_cnt), 0);

      // ---- Round 1, player 1: sel at roll_cnt 0 ignored, three rolls auto-select
      pulse_sel();
      chk("sel_cnt0_ignored", 32'(state_dbg), ST_WAIT);
      for (int i = 0; i < 3; i++) begin
         pulse_roll();
         chk("p1_roll_trigger", 32'(roll_trigger), 1);
         tick();
      end
      chk("auto_select", 32'(state_dbg), ST_SELECT);
      chk("auto_roll_cnt", 32'(roll_cnt), 3);
      chk("auto_entry_idx", 32'(category_idx), 0);
      pulse_roll();
      chk("roll4_no_trigger", 32'(roll_trigger), 0);
      chk("roll4_state", 32'(state_dbg), ST_SELECT);
      chk("roll4_cnt", 32'(roll_cnt), 3);
      calc_score = 8'(p1s[0]);
      pulse_sel();
      tick();
      calc_score = '0;
      wait_turn_or_end();
      chk("r2_round", 32'(round_num), 2);
      chk("r2_player", 32'(player), 0);

      // ---- Round 2
      do_turn(2, p0s[1]);
      do_turn(1, p1s[1]);

      // ---- Round 3, player 0: used = 0b101, cursor walk with wrap
      pulse_roll();
      tick();
      pulse_sel();
      chk("r3_used", 32'(used_mask), 12'b0000_0000_0101);
      chk("r3_entry_idx", 32'(category_idx), 1);
      pulse_next();
      chk("r3_next", 32'(category_idx), 3);
      pulse_prev();
      chk("r3_prev1", 32'(category_idx), 1);
      pulse_prev();
      chk("r3_prev_wrap", 32'(category_idx), 11);
      btn_prev = 1'b1;
      pulse_next();
      btn_prev = 1'b0;
      chk("r3_both_next", 32'(category_idx), 1);
      calc_score = 8'(p0s[2]);
      pulse_sel();
      tick();
      calc_score = '0;
      chk("r3_used_after", 32'(used_mask), 12'b0000_0000_0111);
      wait_turn_or_end();
      do_turn(3, p1s[2]);

      // ---- Rounds 4..12
      for (int r = 4; r <= 12; r++) begin
         do_turn((r % 3) + 1, p0s[r-1]);
         do_turn(((r + 1) % 3) + 1, p1s[r-1]);
         if (r == 6) begin
            chk_score("upper_p0_63", 0, 63);
            chk_score("upper_p1_62", 1, 62);
         end
      end

      // P0: 63 upper + 52 lower + 35 bonus; P1: 62 upper (no bonus) + 88 lower
      chk("end_state", 32'(state_dbg), ST_END);
      chk("end_game_over", 32'(game_over), 1);
      chk("end_winner", 32'(winner), 0);
      chk("end_tie", 32'(tie), 1);
      chk("end_round", 32'(round_num), 12);
      chk_score("end_score_p0", 0, 150);
      chk_score("end_score_p1", 1, 150);
      btn_next = 1'b1; btn_sel = 1'b1; btn_prev = 1'b1;
      tick();
      btn_next = 1'b0; btn_sel = 1'b0; btn_prev = 1'b0;
      chk("end_ignores_nav", 32'(state_dbg), ST_END);
      pulse_roll();
      chk("restart_idle", 32'(state_dbg), ST_IDLE);
      chk("restart_game_over", 32'(game_over), 0);
      chk("restart_tie", 32'(tie), 0);
      chk("restart_used", 32'(used_mask), 0);
      chk_score("restart_score_p0", 0, 0);
      chk_score("restart_score_p1", 1, 0);

      // ---- Game 2: saturation at 1023, then reset during commit
      for (int r = 1; r <= 5; r++) begin
         do_turn(1, 255);
         do_turn(1, 0);
         if (r == 4) chk_score("sat_1020", 0, 1020);
      end
      chk_score("sat_1023", 0, 1023);
      pulse_roll();
      tick();
      pulse_sel();
      calc_score = 8'd50;
      pulse_sel();
      chk("g2_in_commit", 32'(state_dbg), ST_COMMIT);
      reset_n = 1'b0;
      #1;
      chk("arst_state", 32'(state_dbg), ST_IDLE);
      chk("arst_used", 32'(used_mask), 0);
      chk("arst_player", 32'(player), 0);
      chk("arst_round", 32'(round_num), 1);
      chk("arst_trigger", 32'(roll_trigger), 0);
      chk_score("arst_score_p0", 0, 0);
      tick();
      calc_score = '0;
      chk_score("arst_no_commit", 0, 0);
      reset_n = 1'b1;
      tick();
      chk("post_rst_idle", 32'(state_dbg), ST_IDLE);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
